// File: rtl/arb_pkg.sv
// Shared types for the main-memory arbiter: FSM state, transaction owner,
// round-robin pointer (only used when ARB_RR_EN is defined), counter sizing.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN_I,
    OWN_D,
    DRAIN
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_ICACHE,
    OWN_DCACHE
  } owner_t;

  // Requester that was served most recently; the other one wins a tie.
  typedef enum logic {
    RR_I,
    RR_D
  } rr_t;

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/arb_dff.sv
// Plain D flip-flop cell, asynchronous active-high reset to zero.
module arb_dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register the input; clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/arb_out_ctr.sv
// Outstanding-read counter for the arbiter: saturating up/down counter with
// full/empty flags. A decrement on an empty counter is dropped so stray
// responses cannot underflow it; simultaneous inc/dec leaves it unchanged.
module arb_out_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic will_empty
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic         inc_ok;
  logic         dec_ok;

  // Flags and next count; will_empty ignores inc so it can feed the FSM
  // without a combinational path back through the grant logic.
  always_comb begin
    empty      = (cnt == '0);
    full       = (cnt == W'(MAX));
    dec_ok     = dec & ~empty;
    inc_ok     = inc & (~full | dec_ok);
    will_empty = empty | ((cnt == W'(1)) & dec_ok);
    cnt_nxt    = cnt;
    if (inc_ok & ~dec_ok)      cnt_nxt = cnt + 1'b1;
    else if (dec_ok & ~inc_ok) cnt_nxt = cnt - 1'b1;
  end

  arb_dff #(.W(W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .d   (cnt_nxt),
    .q   (cnt)
  );

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter between I-cache and D-cache. Grants whole transactions
// to one cache, counts reads in flight and steers returning data to the owner.
// Optional ARB_RR_EN: round-robin on simultaneous requests in IDLE instead of
// fixed D-over-I priority.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUT);

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  logic   cnt_full, cnt_empty, cnt_will_empty;
  logic   stall;
  logic   win_d;

  assign stall = cnt_full & ~mem_data_valid;

`ifdef ARB_RR_EN
  rr_t rr_ptr;

  // Remember who was served last whenever a transaction leaves OWN_x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     rr_ptr <= RR_I;
    else if (state == OWN_I && state_nxt != OWN_I) rr_ptr <= RR_I;
    else if (state == OWN_D && state_nxt != OWN_D) rr_ptr <= RR_D;
  end

  assign win_d = d_req & (~i_req | (rr_ptr == RR_I));
`else
  assign win_d = d_req;
`endif

  // State and owner registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Next state, owner and grants; owner is held through DRAIN so late
  // responses still reach the cache that issued them.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_wr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_d) begin
          state_nxt = OWN_D;
          owner_nxt = OWN_DCACHE;
        end else if (i_req) begin
          state_nxt = OWN_I;
          owner_nxt = OWN_ICACHE;
        end
      end
      OWN_I: begin
        i_gnt = i_req & ~stall;
        if (!i_req) begin
          if (cnt_will_empty) begin
            state_nxt = IDLE;
            owner_nxt = OWN_NONE;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      OWN_D: begin
        d_gnt  = d_req & ~stall;
        mem_wr = d_wr & d_gnt;
        if (!d_req) begin
          if (cnt_will_empty) begin
            state_nxt = IDLE;
            owner_nxt = OWN_NONE;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt_will_empty) begin
          state_nxt = IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Memory request muxing and response steering.
  always_comb begin
    mem_en       = i_gnt | d_gnt;
    rd_data      = mem_rdata;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    unique case (owner)
      OWN_ICACHE: begin
        mem_addr     = i_addr;
        i_data_valid = mem_data_valid & ~cnt_empty;
      end
      OWN_DCACHE: begin
        mem_addr     = d_addr;
        mem_wdata    = d_wdata;
        d_data_valid = mem_data_valid & ~cnt_empty;
      end
      default: ;
    endcase
  end

  arb_out_ctr #(
    .MAX (MAX_OUT),
    .W   (CNT_W)
  ) u_out_ctr (
    .clk        (clk),
    .rst        (rst),
    .inc        (mem_en & ~mem_wr),
    .dec        (mem_data_valid),
    .full       (cnt_full),
    .empty      (cnt_empty),
    .will_empty (cnt_will_empty)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized transactions against a queue-based model.
module tb_mem_arbiter;

  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, d_gnt, i_data_valid, d_data_valid;
  logic [15:0] rd_data, mem_addr, mem_wdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_rdata = '0;
  logic        mem_data_valid = 1'b0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_data_valid(d_data_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return a * 16'd7 + 16'h1357;
  endfunction

  // ---------------- memory model: in-order reads, configurable latency
  int          mem_lat = 3;
  int          mem_due[$];
  logic [15:0] mem_dat[$];
  int          last_due = 0;
  bit          stray_en = 1'b0;

  always @(negedge clk) begin
    if (mem_en && !mem_wr) begin
      int d;
      d = cyc + mem_lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_due.push_back(d);
      mem_dat.push_back(memfn(mem_addr));
    end
  end

  always @(posedge clk) begin
    #1;
    if (mem_due.size() != 0 && mem_due[0] <= cyc) begin
      mem_data_valid = 1'b1;
      mem_rdata      = mem_dat.pop_front();
      void'(mem_due.pop_front());
    end else begin
      mem_data_valid = stray_en && mem_due.size() == 0 && ($urandom_range(0, 7) == 0);
      mem_rdata      = 16'($urandom);
    end
  end

  // ---------------- event counters for the directed literal checks
  int n_idv = 0, n_ddv = 0, n_wr = 0, last_idv_cyc = 0;
  logic [15:0] wr_addr = '0, wr_dat = '0;

  always @(negedge clk) begin
    if (i_data_valid) begin n_idv++; last_idv_cyc = cyc; end
    if (d_data_valid) n_ddv++;
    if (mem_en && mem_wr) begin n_wr++; wr_addr = mem_addr; wr_dat = mem_wdata; end
  end

  // ---------------- reference model + per-cycle compare
  // m_own: 0 none, 1 I-cache, 2 D-cache. m_q holds expected data of reads in flight.
  int          m_own = 0;
  bit          m_drain = 1'b0;
  logic [15:0] m_q[$];
`ifdef ARB_RR_EN
  int          m_last = 1;
`endif

  always @(negedge clk) begin : model_chk
    bit resp, eg_i, eg_d, e_wr, tie_d, own_req;
    logic [15:0] e_addr;
    chk("rd_pass", rd_data, mem_rdata);
    if (rst) begin
      chk("rst_ctl", {i_gnt, d_gnt, i_data_valid, d_data_valid, mem_en, mem_wr}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      m_own = 0; m_drain = 1'b0; m_q.delete();
`ifdef ARB_RR_EN
      m_last = 1;
`endif
    end else begin
      resp   = mem_data_valid && m_q.size() != 0;
      eg_i   = m_own == 1 && !m_drain && i_req && (m_q.size() < MO || mem_data_valid);
      eg_d   = m_own == 2 && !m_drain && d_req && (m_q.size() < MO || mem_data_valid);
      e_wr   = eg_d && d_wr;
      e_addr = (m_own == 1) ? i_addr : (m_own == 2) ? d_addr : 16'h0;
      chk("i_gnt", i_gnt, eg_i);
      chk("d_gnt", d_gnt, eg_d);
      chk("mem_en", mem_en, eg_i | eg_d);
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_addr", mem_addr, e_addr);
      if (e_wr) chk("mem_wdata", mem_wdata, d_wdata);
      else if (m_own == 0) chk("mem_wdata_idle", mem_wdata, 0);
      chk("i_dv", i_data_valid, resp && m_own == 1);
      chk("d_dv", d_data_valid, resp && m_own == 2);
      if (resp) begin
        chk("rd_data", rd_data, m_q[0]);
        void'(m_q.pop_front());
      end
      if ((eg_i || eg_d) && !e_wr) m_q.push_back(memfn(e_addr));
`ifdef ARB_RR_EN
      tie_d = (m_last == 1);
`else
      tie_d = 1'b1;
`endif
      if (m_own == 0) begin
        if (d_req && (!i_req || tie_d)) m_own = 2;
        else if (i_req)                 m_own = 1;
      end else if (!m_drain) begin
        own_req = (m_own == 1) ? i_req : d_req;
        if (!own_req) begin
`ifdef ARB_RR_EN
          m_last = m_own;
`endif
          if (m_q.size() == 0) m_own = 0;
          else                 m_drain = 1'b1;
        end
      end else if (m_q.size() == 0) begin
        m_own = 0; m_drain = 1'b0;
      end
    end
  end

  // ---------------- cache-side stimulus
  int order[$];   // 1 = D, 0 = I, pushed at each transaction's first grant

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic xfer(input bit is_d, input bit wr, input int n,
                      input logic [15:0] base, input logic [15:0] wbase,
                      output int fcyc, output int lat);
    int got = 0, g = 0, start = cyc;
    bit first = 1'b1;
    fcyc = 0;
    if (is_d) begin d_req = 1'b1; d_wr = wr; d_addr = base; d_wdata = wbase; end
    else      begin i_req = 1'b1; i_addr = base; end
    while (got < n && g < 300) begin
      tick(); g++;
      if (is_d) begin d_addr = base + 16'(got); d_wdata = wbase + 16'(got); end
      else        i_addr = base + 16'(got);
      #1;
      if (is_d ? d_gnt : i_gnt) begin
        if (first) begin order.push_back(int'(is_d)); fcyc = cyc; first = 1'b0; end
        got++;
      end
    end
    chk(is_d ? "d_xfer_grants" : "i_xfer_grants", got, n);
    lat = fcyc - start;
    tick();
    if (is_d) begin d_req = 1'b0; d_wr = 1'b0; end
    else        i_req = 1'b0;
  endtask

  task automatic settle();
    int g = 0;
    while (mem_due.size() != 0 && g < 500) begin tick(); g++; end
    if (g >= 500) chk("settle_timeout", g, 0);
    repeat (3) tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int fa, la, fb, lb, s_i, s_d, s_w, s_o, exp3[4];
    logic [15:0] ra, rw;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick(); #1;
    chk("post_rst_quiet", {i_gnt, d_gnt, mem_en, i_data_valid, d_data_valid}, 0);

    // 1: I-cache alone, 8 reads, latency 4
    mem_lat = 4; s_i = n_idv; s_d = n_ddv;
    xfer(1'b0, 1'b0, 8, 16'h0100, 16'h0, fa, la);
    settle();
    chk("t1_gnt_latency", la, 1);
    chk("t1_i_valids", n_idv - s_i, 8);
    chk("t1_d_valids", n_ddv - s_d, 0);

    // 2: simultaneous requests, D first, I one cycle after D's drain ends
    mem_lat = 3; s_o = order.size();
    fork
      xfer(1'b1, 1'b0, 4, 16'h0200, 16'h0, fa, la);
      xfer(1'b0, 1'b0, 4, 16'h0300, 16'h0, fb, lb);
    join
    settle();
    chk("t2_first_owner_d", order[s_o], 1);
    chk("t2_i_after_d", fb - fa, 8);

    // 3: both caches re-request repeatedly
    mem_lat = 2; s_o = order.size();
`ifdef ARB_RR_EN
    exp3 = '{1, 0, 1, 0};
`else
    exp3 = '{1, 1, 0, 0};
`endif
    fork
      begin repeat (2) begin xfer(1'b1, 1'b0, 2, 16'h0400, 16'h0, fa, la); tick(); end end
      begin repeat (2) begin xfer(1'b0, 1'b0, 2, 16'h0480, 16'h0, fb, lb); tick(); end end
    join
    settle();
    for (int k = 0; k < 4; k++) chk($sformatf("t3_order%0d", k), order[s_o + k], exp3[k]);

    // 4: write-through
    s_w = n_wr; s_i = n_idv; s_d = n_ddv;
    xfer(1'b1, 1'b1, 1, 16'h1234, 16'hBEEF, fa, la);
    settle();
    chk("t4_wr_cycles", n_wr - s_w, 1);
    chk("t4_wr_addr", wr_addr, 16'h1234);
    chk("t4_wr_data", wr_dat, 16'hBEEF);
    chk("t4_no_resp", (n_idv - s_i) + (n_ddv - s_d), 0);

    // 5: I drops with 3 reads in flight, D waits for the drain
    mem_lat = 6; s_i = n_idv;
    fork
      xfer(1'b0, 1'b0, 3, 16'h0500, 16'h0, fa, la);
      begin tick(); tick(); xfer(1'b1, 1'b0, 2, 16'h0600, 16'h0, fb, lb); end
    join
    settle();
    chk("t5_drain_valids", n_idv - s_i, 3);
    chk("t5_d_after_drain", fb - last_idv_cyc, 2);

    // 6: reset with 2 reads in flight; late responses are dropped
    mem_lat = 5;
    i_req = 1'b1; i_addr = 16'h0700;
    tick(); i_addr = 16'h0701;
    tick(); i_addr = 16'h0702;
    tick(); i_req = 1'b0; rst = 1'b1;
    s_i = n_idv; s_d = n_ddv;
    tick(); rst = 1'b0;
    repeat (10) tick();
    chk("t6_stray_dropped", (n_idv - s_i) + (n_ddv - s_d), 0);
    chk("t6_mem_drained", mem_due.size(), 0);
    s_i = n_idv;
    xfer(1'b0, 1'b0, 2, 16'h0800, 16'h0, fa, la);
    settle();
    chk("t6_fresh_fill", n_idv - s_i, 2);

    // randomized mix, model-checked every cycle
    stray_en = 1'b1;
    repeat (60) begin
      mem_lat = $urandom_range(1, 6);
      ra = 16'($urandom); rw = 16'($urandom);
      case ($urandom_range(0, 3))
        0: xfer(1'b0, 1'b0, $urandom_range(1, 6), ra, rw, fa, la);
        1: xfer(1'b1, 1'b0, $urandom_range(1, 6), ra, rw, fa, la);
        2: xfer(1'b1, 1'b1, 1, ra, rw, fa, la);
        default: begin
          automatic bit w = 1'($urandom_range(0, 1));
          fork
            xfer(1'b0, 1'b0, $urandom_range(1, 6), ra, rw, fa, la);
            xfer(1'b1, w, w ? 1 : $urandom_range(1, 6), rw, ra, fb, lb);
          join
        end
      endcase
      settle();
    end
    stray_en = 1'b0;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
